// File: rtl/fpu_pkg.sv
// Shared FPU constants and the inter-stage payloads of the float->int64 converter.
package fpu_pkg;

  localparam int unsigned FPU_EXP_W = 10;
  localparam int unsigned FPU_MAN_W = 53;
  localparam int unsigned FPU_BIAS  = 511;

  // Unbiased exponent carries one extra bit so it can go negative.
  localparam int unsigned FPU_E_W   = FPU_EXP_W + 1;
  // Significand including the implicit leading one.
  localparam int unsigned FPU_SIG_W = FPU_MAN_W + 1;
  localparam int unsigned INT_W     = 64;

  localparam logic [INT_W-1:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [INT_W-1:0] INT64_MIN = 64'h8000_0000_0000_0000;

  // Exponent classification produced by decode.
  typedef struct packed {
    logic [FPU_E_W-1:0] e;       // unbiased exponent, two's complement
    logic               zero;    // exponent field is 0
    logic               big;     // e > 62
    logic               edge63;  // e == 63
    logic               frac;    // e < 0
    logic               left;    // e > 53, integer needs a left shift
  } fpu_cls_t;

  // Decode -> shift stage payload.
  typedef struct packed {
    logic                 sign;
    logic                 rnd;
    logic                 mant_zero;
    logic [FPU_SIG_W-1:0] sig;
    fpu_cls_t             cls;
  } fpu_s1_t;

  // Shift -> round stage payload.
  typedef struct packed {
    logic             sign;
    logic             rnd;
    logic             zero;
    logic             ovf_pre;   // overflow known from the exponent alone
    logic [INT_W-1:0] ival;      // truncated integer magnitude
    logic             rbit;      // first bit below the binary point
  } fpu_s2_t;

endpackage

// File: rtl/fpu_rshift_sticky.sv
// Right shift of the significand by 0..63 with round and sticky extraction.
module fpu_rshift_sticky
  import fpu_pkg::*;
(
  input  logic [FPU_SIG_W-1:0] val,
  input  logic [5:0]           sh,
  output logic [FPU_SIG_W-1:0] shifted_c,
  output logic                 rbit_c,
  output logic                 sticky_c
);

  localparam int unsigned EXT_W = FPU_SIG_W + INT_W;

  // Shifting into a zero-extended window keeps the bits that fall off the bottom.
  logic [EXT_W-1:0] ext;

  assign ext       = {val, {INT_W{1'b0}}} >> sh;
  assign shifted_c = ext[EXT_W-1 -: FPU_SIG_W];
  assign rbit_c    = ext[INT_W-1];
  assign sticky_c  = |ext[INT_W-2:0];

endmodule

// File: rtl/fpu_cvt_f2i64.sv
// Internal 64-bit float to signed int64 converter, 3-stage pipeline with valid/ready.
module fpu_cvt_f2i64
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [INT_W-1:0] A,
  input  logic             rnd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [INT_W-1:0] res,
  output logic             ovf
);

  // Whole pipe advances together whenever the output slot is free or draining.
  logic adv;
  assign adv    = !out_vld | out_rdy;
  assign in_rdy = adv;

  // ---------------- S1: decode ----------------
  logic [FPU_EXP_W-1:0]      a_exp;
  logic signed [FPU_E_W-1:0] e_c;
  fpu_s1_t                   s1_d, s1_q;
  logic                      s1_vld;

  assign a_exp = A[FPU_MAN_W +: FPU_EXP_W];
  assign e_c   = $signed(FPU_E_W'({1'b0, a_exp}) - FPU_E_W'(FPU_BIAS));

  // Unbias the exponent and classify the operand range.
  always_comb begin
    s1_d            = '0;
    s1_d.sign       = A[INT_W-1];
    s1_d.rnd        = rnd;
    s1_d.mant_zero  = (A[FPU_MAN_W-1:0] == '0);
    s1_d.sig        = {1'b1, A[FPU_MAN_W-1:0]};
    s1_d.cls.e      = e_c;
    s1_d.cls.zero   = (a_exp == '0);
    s1_d.cls.big    = (e_c > $signed(FPU_E_W'(62)));
    s1_d.cls.edge63 = (e_c == $signed(FPU_E_W'(63)));
    s1_d.cls.frac   = (e_c < $signed(FPU_E_W'(0)));
    s1_d.cls.left   = (e_c > $signed(FPU_E_W'(FPU_MAN_W)));
  end

  // S1 register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (adv) begin
      s1_vld <= in_vld;
      s1_q   <= s1_d;
    end
  end

  // ---------------- S2: shift ----------------
  logic [5:0]           rsh_amt;
  logic [3:0]           lsh_amt;
  logic [FPU_SIG_W-1:0] rsh_val;
  logic                 rsh_rbit;
  logic                 rsh_sticky_unused;  // ties do not look at sticky
  fpu_s2_t              s2_d, s2_q;
  logic                 s2_vld;

  // Meaningful for -1 <= e <= 53 (right shift 54..0) and 54 <= e <= 63 (left shift 1..10).
  assign rsh_amt = 6'(FPU_E_W'(FPU_MAN_W) - s1_q.cls.e);
  assign lsh_amt = 4'(s1_q.cls.e - FPU_E_W'(FPU_MAN_W));

  fpu_rshift_sticky u_rshift (
    .val       (s1_q.sig),
    .sh        (rsh_amt),
    .shifted_c (rsh_val),
    .rbit_c    (rsh_rbit),
    .sticky_c  (rsh_sticky_unused)
  );

  // Align the significand to the integer grid and flag exponent-only overflow.
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.rnd     = s1_q.rnd;
    s2_d.zero    = s1_q.cls.zero;
    s2_d.ovf_pre = !s1_q.cls.zero &
                   ((s1_q.cls.big & !s1_q.cls.edge63) |
                    (s1_q.cls.edge63 & !(s1_q.sign & s1_q.mant_zero)));
    if (s1_q.cls.zero || (s1_q.cls.big && !s1_q.cls.edge63)) begin
      s2_d.ival = '0;
      s2_d.rbit = 1'b0;
    end else if (s1_q.cls.left) begin
      s2_d.ival = {{(INT_W-FPU_SIG_W){1'b0}}, s1_q.sig} << lsh_amt;
      s2_d.rbit = 1'b0;
    end else if (!s1_q.cls.frac || (s1_q.cls.e == '1)) begin
      s2_d.ival = {{(INT_W-FPU_SIG_W){1'b0}}, rsh_val};
      s2_d.rbit = rsh_rbit;
    end else begin
      s2_d.ival = '0;
      s2_d.rbit = 1'b0;
    end
  end

  // S2 register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld <= 1'b0;
      s2_q   <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      s2_q   <= s2_d;
    end
  end

  // ---------------- S3: round / sign / saturate ----------------
  logic [INT_W-1:0] mag_c;
  logic [INT_W-1:0] res_c;
  logic             ovf_c;

  // Round half away from zero by adding the round bit to the magnitude.
  always_comb begin
    mag_c = s2_q.ival + INT_W'(s2_q.rnd & s2_q.rbit);
    // 2^63 is representable only as the negative extreme.
    ovf_c = !s2_q.zero &
            (s2_q.ovf_pre |
             (mag_c[INT_W-1] & !(s2_q.sign & (mag_c[INT_W-2:0] == '0))));
    if (s2_q.zero) begin
      res_c = '0;
    end else if (ovf_c) begin
      res_c = s2_q.sign ? INT64_MIN : INT64_MAX;
    end else if (s2_q.sign) begin
      res_c = INT_W'(0) - mag_c;
    end else begin
      res_c = mag_c;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      res     <= '0;
      ovf     <= 1'b0;
    end else if (adv) begin
      out_vld <= s2_vld;
      res     <= res_c;
      ovf     <= ovf_c;
    end
  end

endmodule

// File: tb/tb_fpu_cvt_f2i64.sv
// Self-checking bench: directed table, backpressure, reset and randomized traffic.
module tb_fpu_cvt_f2i64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [63:0] A = '0;
  logic        rnd = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [63:0] res;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  bit rand_done = 1'b0;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic        r;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[18];

  always #5 clk = ~clk;

  fpu_cvt_f2i64 dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .A       (A),
    .rnd     (rnd),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .res     (res),
    .ovf     (ovf)
  );

  // Reference: value = M * 2^(e-53) evaluated in wide integer arithmetic.
  function automatic exp_t model(input logic [63:0] a, input logic r);
    exp_t         o;
    int           e;
    logic [255:0] m;
    logic [255:0] q;
    logic [255:0] two63;
    logic [63:0]  lo;
    o.res = '0;
    o.ovf = 1'b0;
    if (a[62:53] == 10'd0) return o;
    e     = int'(a[62:53]) - 511;
    m     = (256'(1) << 53) | 256'(a[52:0]);
    two63 = 256'(1) << 63;
    if (e > 100)      q = 256'(1) << 120;
    else if (e >= 53) q = m << (e - 53);
    else if (e < -3)  q = '0;
    else if (r)       q = ((m << 1) + (256'(1) << (53 - e))) >> (54 - e);
    else              q = m >> (53 - e);
    lo = q[63:0];
    if (a[63]) begin
      if (q > two63) begin o.res = 64'h8000_0000_0000_0000; o.ovf = 1'b1; end
      else o.res = 64'd0 - lo;
    end else if (q >= two63) begin
      o.res = 64'h7FFF_FFFF_FFFF_FFFF; o.ovf = 1'b1;
    end else begin
      o.res = lo;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: record accepts, compare every valid output cycle against the model.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (in_vld && in_rdy) begin
        exp_q.push_back(model(A, rnd));
        acc_cnt++;
      end
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_spurious: out_vld=1 res=%h with no outstanding operand", res);
        end else begin
          check("sb_res", res, exp_q[0].res);
          check("sb_ovf", 64'(ovf), 64'(exp_q[0].ovf));
          if (out_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one operand from posedge+1 until it is accepted (bounded).
  task automatic send(input logic [63:0] a, input logic r);
    int   budget;
    logic acc;
    budget = 200;
    acc    = 1'b0;
    A      = a;
    rnd    = r;
    in_vld = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      budget--;
    end
    in_vld = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: operand %h not accepted, expected accept", a);
    end
  endtask

  // Single operand into an empty pipe: exact 3-cycle latency and constant result.
  task automatic run_vec(input vec_t v, input int idx);
    send(v.a, v.r);
    check($sformatf("vec%0d_early1", idx), 64'(out_vld), 64'd0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_early2", idx), 64'(out_vld), 64'd0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_vld", idx), 64'(out_vld), 64'd1);
    check($sformatf("vec%0d_res", idx), res, v.res);
    check($sformatf("vec%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] a;
    logic [9:0]  ex;
    int          k;
    a = {$urandom, $urandom};
    k = int'($urandom_range(0, 9));
    if (k == 0)      ex = 10'd0;
    else if (k == 1) ex = 10'($urandom);
    else             ex = 10'($urandom_range(500, 580));
    a[62:53] = ex;
    if ($urandom_range(0, 3) == 0) a[52:0] = 53'(64'(1) << $urandom_range(0, 52));
    return a;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc0;
    vecs[0]  = '{64'h3FE0_0000_0000_0000, 1'b0, 64'd1, 1'b0};
    vecs[1]  = '{64'h4008_0000_0000_0000, 1'b0, 64'd2, 1'b0};
    vecs[2]  = '{64'h4008_0000_0000_0000, 1'b1, 64'd3, 1'b0};
    vecs[3]  = '{64'hC008_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[4]  = '{64'hC008_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[5]  = '{64'h3FC0_0000_0000_0000, 1'b1, 64'd1, 1'b0};
    vecs[6]  = '{64'h3FC0_0000_0000_0000, 1'b0, 64'd0, 1'b0};
    vecs[7]  = '{64'h8000_0000_0000_0123, 1'b1, 64'd0, 1'b0};
    vecs[8]  = '{64'h47C0_0000_0000_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[9]  = '{64'hC7C0_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[10] = '{64'hC7C0_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[11] = '{64'hFFE0_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1};
    vecs[12] = '{64'h47BF_FFFF_FFFF_FFFF, 1'b1, 64'h7FFF_FFFF_FFFF_FE00, 1'b0};
    vecs[13] = '{64'h3FF0_0000_0000_0000, 1'b1, 64'd2, 1'b0};
    vecs[14] = '{64'h3FF0_0000_0000_0000, 1'b0, 64'd1, 1'b0};
    vecs[15] = '{64'hBFC0_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[16] = '{64'h3FA0_0000_0000_0000, 1'b1, 64'd0, 1'b0};
    vecs[17] = '{64'h4680_0000_0000_0001, 1'b0, 64'h0020_0000_0000_0001, 1'b0};

    // Reset state.
    #12;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_rdy = 1'b1;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;

    // Directed table.
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: six back-to-back operands with the consumer stalled for 5 cycles.
    out_rdy = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_op(), 1'($urandom));
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_accepts", 64'(acc_cnt - acc0), 64'd3);
        check("bp_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_total", 64'(acc_cnt - acc0), 64'd6);

    // Reset with operands in flight.
    for (int i = 0; i < 3; i++) send(rand_op(), 1'($urandom));
    check("mid_rst_pre_vld", 64'(out_vld), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_vld", 64'(out_vld), 64'd0);
    check("mid_rst_res", res, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_vld", 64'(out_vld), 64'd0);
    run_vec(vecs[2], 100);

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          send(rand_op(), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_rdy = 1'b1;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
